cam_alloc: RTL

- Free-entry allocator directly upstream of the multi-port CAM.
- Owns a circular free list of CAM entry indices and hands out up to WRITE entry addresses per cycle; these drive the CAM `waddr`/`we_` ports.
- Accepts up to FREE released entry indices per cycle and returns them to the list.
- Tracks which entries are allocated, so double frees and frees of unallocated entries are rejected and flagged.

---
 rtl/cam_alloc_pkg.sv | 20 ++
 rtl/cam_alloc_prefix_cnt.sv | 26 ++
 rtl/cam_alloc.sv | 115 +++++++++++
 3 files changed

// File: rtl/cam_alloc_pkg.sv
// Shared types and constants for the CAM free-entry allocator.
// Entry/count typedefs are sized for the default 32-entry CAM.
package cam_alloc_pkg;

   localparam int DEF_DEPTH = 32;
   localparam int DEF_ADDR  = $clog2(DEF_DEPTH);
   localparam int DEF_CNT   = DEF_ADDR + 1;

   typedef logic [DEF_ADDR-1:0] entry_t;
   typedef logic [DEF_CNT-1:0]  count_t;

   // Reset is asserted while the reset pin is low.
   localparam logic RESET_ACTIVE = 1'b0;

   // Width needed to hold a population count of an n-bit vector (0..n).
   function automatic int clog2_cnt(input int n);
      return $clog2(n + 1);
   endfunction

endpackage

// File: rtl/cam_alloc_prefix_cnt.sv
// Inclusive prefix population count: prefix[i] = number of set bits in bits[0..i].
// The final prefix is also presented as the total.
module cam_alloc_prefix_cnt
   import cam_alloc_pkg::*;
#(
   parameter int N = 4,
   parameter int W = clog2_cnt(N)
) (
   input  logic [N-1:0]        bits,
   output logic [N-1:0][W-1:0] prefix,
   output logic [W-1:0]        total
);

   logic [W-1:0] acc;

   always_comb begin
      acc    = '0;
      prefix = '0;
      for (int i = 0; i < N; i++) begin
         acc       = acc + W'(bits[i]);
         prefix[i] = acc;
      end
      total = acc;
   end

endmodule

// File: rtl/cam_alloc.sv
// Circular free-list allocator feeding CAM write addresses. Grants up to WRITE
// entries per cycle, accepts up to FREE releases, and rejects invalid releases.
module cam_alloc
   import cam_alloc_pkg::*;
#(
   parameter int DEPTH = 32,
   parameter int WRITE = 4,
   parameter int FREE  = 4,
   parameter int ADDR  = $clog2(DEPTH),
   parameter int CNT   = ADDR + 1
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic [WRITE-1:0]           alloc_req,
   output logic [WRITE-1:0]           alloc_ok,
   output logic [WRITE-1:0][ADDR-1:0] alloc_addr,
   input  logic [FREE-1:0]            free_en,
   input  logic [FREE-1:0][ADDR-1:0]  free_addr,
   output logic [CNT-1:0]             free_cnt,
   output logic                       empty,
   output logic [FREE-1:0]            free_err
);

   localparam int WG = clog2_cnt(WRITE);
   localparam int WF = clog2_cnt(FREE);

   logic [ADDR-1:0]  list_reg [DEPTH];
   logic [ADDR-1:0]  head_reg;
   logic [ADDR-1:0]  tail_reg;
   logic [CNT-1:0]   cnt_reg;
   logic [DEPTH-1:0] alloc_v_reg;
   logic [FREE-1:0]  free_err_reg;
   logic             empty_reg;

   logic [WRITE-1:0][WG-1:0] req_prefix;
   logic [WG-1:0]            req_total;
   logic [FREE-1:0]          rel_valid;
   logic [FREE-1:0][WF-1:0]  rel_prefix;
   logic [WF-1:0]            rel_total;
   logic [CNT-1:0]           grant_cnt;
   logic [CNT-1:0]           cnt_next;

   cam_alloc_prefix_cnt #(.N(WRITE), .W(WG)) u_req_prefix (
      .bits   (alloc_req),
      .prefix (req_prefix),
      .total  (req_total)
   );

   cam_alloc_prefix_cnt #(.N(FREE), .W(WF)) u_rel_prefix (
      .bits   (rel_valid),
      .prefix (rel_prefix),
      .total  (rel_total)
   );

   // Grants fill in port order against the registered count only, so a
   // denied requester implies every higher requester is denied as well.
   for (genvar gi = 0; gi < WRITE; gi++) begin : g_alloc
      logic [ADDR-1:0] slot;
      assign alloc_ok[gi]   = alloc_req[gi] && (CNT'(req_prefix[gi]) <= cnt_reg);
      assign slot           = alloc_req[gi] ? head_reg + ADDR'(req_prefix[gi]) - ADDR'(1)
                                            : head_reg;
      assign alloc_addr[gi] = list_reg[slot];
   end

   // A release is valid only for an allocated entry not already released by a lower port.
   for (genvar gi = 0; gi < FREE; gi++) begin : g_free
      logic dup;
      always_comb begin
         dup = 1'b0;
         for (int j = 0; j < gi; j++) begin
            if (free_en[j] && (free_addr[j] == free_addr[gi])) dup = 1'b1;
         end
      end
      assign rel_valid[gi] = free_en[gi] && alloc_v_reg[free_addr[gi]] && !dup;
   end

   // Grant total is the request count clipped to what is available.
   assign grant_cnt = (CNT'(req_total) < cnt_reg) ? CNT'(req_total) : cnt_reg;
   assign cnt_next  = cnt_reg - grant_cnt + CNT'(rel_total);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < DEPTH; i++) list_reg[i] <= ADDR'(i);
         head_reg     <= '0;
         tail_reg     <= '0;
         cnt_reg      <= CNT'(DEPTH);
         alloc_v_reg  <= '0;
         free_err_reg <= '0;
         empty_reg    <= 1'b0;
      end else begin
         head_reg     <= head_reg + ADDR'(grant_cnt);
         tail_reg     <= tail_reg + ADDR'(rel_total);
         cnt_reg      <= cnt_next;
         empty_reg    <= (cnt_next == '0);
         free_err_reg <= free_en & ~rel_valid;
         for (int j = 0; j < FREE; j++) begin
            if (rel_valid[j])
               list_reg[tail_reg + ADDR'(rel_prefix[j]) - ADDR'(1)] <= free_addr[j];
         end
         // Granted entries are free at evaluation time and valid releases are
         // allocated, so the set and clear targets never overlap.
         for (int i = 0; i < WRITE; i++) begin
            if (alloc_ok[i]) alloc_v_reg[alloc_addr[i]] <= 1'b1;
         end
         for (int j = 0; j < FREE; j++) begin
            if (rel_valid[j]) alloc_v_reg[free_addr[j]] <= 1'b0;
         end
      end
   end

   assign free_cnt = cnt_reg;
   assign empty    = empty_reg;
   assign free_err = free_err_reg;

endmodule
